// File: rtl/vend_txn_ctrl.sv
// Vending-machine transaction controller: coin credit, product selection,
// dispenser handshake with timeout refund, and change payout in quarters/nickels.
module vend_txn_ctrl #(
  parameter int unsigned PRICE_0      = 10,
  parameter int unsigned PRICE_1      = 25,
  parameter int unsigned PRICE_2      = 35,
  parameter int unsigned PRICE_3      = 100,
  parameter int unsigned CREDIT_MAX   = 500,
  parameter int unsigned DISP_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dime,
  input  logic       quarter,
  input  logic       dollar,
  input  logic       cancel,
  input  logic [3:0] sel,
  input  logic [3:0] stock,
  output logic       disp_req,
  output logic [1:0] disp_id,
  input  logic       disp_done,
  output logic       chg_req,
  output logic       chg_coin,
  input  logic       chg_ack,
  output logic [9:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       sold_out,
  output logic       vend_led,
  output logic       fault
);

  localparam int unsigned TW = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_DISPENSE, ST_CHANGE} state_t;

  state_t        state, state_nx;
  logic [9:0]    credit_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          disp_req_nx, chg_req_nx, chg_coin_nx;
  logic [1:0]    disp_id_nx;
  logic          coin_reject_nx, sold_out_nx, vend_led_nx, fault_nx;

  logic [1:0]    n_coins;
  logic [10:0]   coin_val, coin_sum;
  logic [1:0]    sel_id;
  logic [9:0]    sel_price, chg_val;

  function automatic logic [9:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    return 10'(PRICE_0);
      2'd1:    return 10'(PRICE_1);
      2'd2:    return 10'(PRICE_2);
      default: return 10'(PRICE_3);
    endcase
  endfunction

  assign busy = (state == ST_DISPENSE) || (state == ST_CHANGE);

  always_comb begin
    n_coins   = 2'(dime) + 2'(quarter) + 2'(dollar);
    coin_val  = dime ? 11'd10 : quarter ? 11'd25 : dollar ? 11'd100 : 11'd0;
    coin_sum  = {1'b0, credit} + coin_val;
    sel_id    = {sel[3] | sel[2], sel[3] | sel[1]};
    sel_price = price_of(sel_id);
    chg_val   = chg_coin ? 10'd25 : 10'd5;

    state_nx       = state;
    credit_nx      = credit;
    timer_nx       = timer;
    disp_req_nx    = disp_req;
    disp_id_nx     = disp_id;
    chg_req_nx     = chg_req;
    chg_coin_nx    = chg_coin;
    coin_reject_nx = 1'b0;
    sold_out_nx    = 1'b0;
    vend_led_nx    = 1'b0;
    fault_nx       = 1'b0;

    // Coins landing while the machine is busy always go straight to the chute.
    if (busy && n_coins != 2'd0)
      coin_reject_nx = 1'b1;

    case (state)
      ST_IDLE, ST_CREDIT: begin
        // Any coin activity in a cycle takes precedence over sel and cancel.
        if (n_coins != 2'd0) begin
          if (n_coins > 2'd1 || coin_sum > 11'(CREDIT_MAX)) begin
            coin_reject_nx = 1'b1;
          end else begin
            credit_nx = coin_sum[9:0];
            state_nx  = ST_CREDIT;
          end
        end else if (state == ST_CREDIT) begin
          if (cancel) begin
            state_nx = ST_CHANGE;
          end else if ($onehot(sel)) begin
            if (!stock[sel_id]) begin
              sold_out_nx = 1'b1;
            end else if (credit >= sel_price) begin
              credit_nx   = credit - sel_price;
              disp_req_nx = 1'b1;
              disp_id_nx  = sel_id;
              timer_nx    = '0;
              state_nx    = ST_DISPENSE;
            end
          end
        end
      end

      ST_DISPENSE: begin
        if (disp_done) begin
          disp_req_nx = 1'b0;
          vend_led_nx = 1'b1;
          state_nx    = (credit != '0) ? ST_CHANGE : ST_IDLE;
        end else if (timer == TW'(DISP_TIMEOUT - 1)) begin
          disp_req_nx = 1'b0;
          fault_nx    = 1'b1;
          credit_nx   = credit + price_of(disp_id);
          state_nx    = ST_CHANGE;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      ST_CHANGE: begin
        // Request rises one cycle after entry or after each ack, giving the gap.
        if (chg_req) begin
          if (chg_ack) begin
            chg_req_nx = 1'b0;
            credit_nx  = credit - chg_val;
            if (credit == chg_val)
              state_nx = ST_IDLE;
          end
        end else if (credit != '0) begin
          chg_req_nx  = 1'b1;
          chg_coin_nx = (credit >= 10'd25);
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      credit      <= '0;
      timer       <= '0;
      disp_req    <= 1'b0;
      disp_id     <= '0;
      chg_req     <= 1'b0;
      chg_coin    <= 1'b0;
      coin_reject <= 1'b0;
      sold_out    <= 1'b0;
      vend_led    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      timer       <= timer_nx;
      disp_req    <= disp_req_nx;
      disp_id     <= disp_id_nx;
      chg_req     <= chg_req_nx;
      chg_coin    <= chg_coin_nx;
      coin_reject <= coin_reject_nx;
      sold_out    <= sold_out_nx;
      vend_led    <= vend_led_nx;
      fault       <= fault_nx;
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: inputs driven and outputs sampled on the
// falling edge, expected values computed by hand from the pricing rules.
module tb_vend_txn_ctrl;

  localparam int unsigned DT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dime = 1'b0, quarter = 1'b0, dollar = 1'b0, cancel = 1'b0;
  logic [3:0] sel = '0;
  logic [3:0] stock = 4'b1111;
  logic       disp_req, chg_req, chg_coin, busy;
  logic [1:0] disp_id;
  logic       disp_done = 1'b0, chg_ack = 1'b0;
  logic [9:0] credit;
  logic       coin_reject, sold_out, vend_led, fault;

  int n_cmp = 0;
  int n_err = 0;

  vend_txn_ctrl #(
    .PRICE_0(10), .PRICE_1(25), .PRICE_2(35), .PRICE_3(100),
    .CREDIT_MAX(500), .DISP_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dime(dime), .quarter(quarter), .dollar(dollar), .cancel(cancel),
    .sel(sel), .stock(stock),
    .disp_req(disp_req), .disp_id(disp_id), .disp_done(disp_done),
    .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .credit(credit), .busy(busy),
    .coin_reject(coin_reject), .sold_out(sold_out),
    .vend_led(vend_led), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put_dime();    dime = 1'b1;    step(); dime = 1'b0;    endtask
  task automatic put_quarter(); quarter = 1'b1; step(); quarter = 1'b0; endtask
  task automatic put_dollar();  dollar = 1'b1;  step(); dollar = 1'b0;  endtask

  // Entered with chg_req low: expects one full request/ack round.
  task automatic change_coin(input string tag, input logic exp_coin, input int exp_credit);
    step();
    chk({tag, "_req"}, chg_req, 1);
    chk({tag, "_coin"}, chg_coin, exp_coin);
    step();
    chk({tag, "_hold"}, chg_req, 1);
    chk({tag, "_coin_hold"}, chg_coin, exp_coin);
    chg_ack = 1'b1;
    step();
    chg_ack = 1'b0;
    chk({tag, "_gap"}, chg_req, 0);
    chk({tag, "_credit"}, credit, exp_credit);
  endtask

  task automatic drain_change();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    for (int i = 0; i < 400 && busy; i++) begin
      chg_ack = chg_req;
      step();
    end
    chg_ack = 1'b0;
    chk("drain_busy", busy, 0);
    chk("drain_credit", credit, 0);
  endtask

  initial begin
    // Reset
    step(); step();
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp_req", disp_req, 0);
    chk("rst_chg_req", chg_req, 0);
    rst_n = 1'b1;

    // Exact vend: 25 + 10 buys product 2
    put_quarter();
    chk("ev_credit25", credit, 25);
    chk("ev_busy_credit", busy, 0);
    put_dime();
    chk("ev_credit35", credit, 35);
    sel = 4'b0100; step(); sel = '0;
    chk("ev_disp_req", disp_req, 1);
    chk("ev_disp_id", disp_id, 2);
    chk("ev_credit0", credit, 0);
    chk("ev_busy", busy, 1);
    step(); step();
    chk("ev_req_held", disp_req, 1);
    disp_done = 1'b1; step(); disp_done = 1'b0;
    chk("ev_req_drop", disp_req, 0);
    chk("ev_vend_led", vend_led, 1);
    chk("ev_idle", busy, 0);
    step();
    chk("ev_led_pulse", vend_led, 0);

    // Change: dollar buys product 0, 90c paid back as 3 quarters + 3 nickels
    put_dollar();
    chk("ch_credit100", credit, 100);
    sel = 4'b0001; step(); sel = '0;
    chk("ch_credit90", credit, 90);
    chk("ch_disp_id", disp_id, 0);
    disp_done = 1'b1; step(); disp_done = 1'b0;
    chk("ch_vend_led", vend_led, 1);
    chk("ch_busy", busy, 1);
    chk("ch_req_low", chg_req, 0);
    change_coin("ch_q1", 1'b1, 65);
    change_coin("ch_q2", 1'b1, 40);
    change_coin("ch_q3", 1'b1, 15);
    change_coin("ch_n1", 1'b0, 10);
    change_coin("ch_n2", 1'b0, 5);
    change_coin("ch_n3", 1'b0, 0);
    chk("ch_idle", busy, 0);
    chg_ack = 1'b1; step(); chg_ack = 1'b0;
    chk("ch_stray_ack", chg_req, 0);
    disp_done = 1'b1; step(); disp_done = 1'b0;
    chk("stray_done_led", vend_led, 0);

    // Rejects
    dime = 1'b1; quarter = 1'b1; step(); dime = 1'b0; quarter = 1'b0;
    chk("rj_multi", coin_reject, 1);
    chk("rj_multi_credit", credit, 0);
    step();
    chk("rj_pulse", coin_reject, 0);
    for (int i = 0; i < 4; i++) put_dollar();
    put_quarter(); put_quarter();
    chk("rj_credit450", credit, 450);
    put_dollar();
    chk("rj_over", coin_reject, 1);
    chk("rj_over_credit", credit, 450);
    put_quarter(); put_quarter();
    chk("rj_credit_max", credit, 500);
    chk("rj_max_ok", coin_reject, 0);
    put_dime();
    chk("rj_over_max", coin_reject, 1);
    chk("rj_max_credit", credit, 500);
    drain_change();
    put_dime();
    sel = 4'b0001; step(); sel = '0;
    chk("rj_disp_enter", disp_req, 1);
    put_quarter();
    chk("rj_busy_coin", coin_reject, 1);
    chk("rj_busy_credit", credit, 0);
    chk("rj_busy_req", disp_req, 1);
    disp_done = 1'b1; step(); disp_done = 1'b0;
    chk("rj_done_idle", busy, 0);

    // Sold out / insufficient credit / multi-bit sel
    put_quarter();
    stock = 4'b0111;
    sel = 4'b1000; step(); sel = '0;
    chk("so_pulse", sold_out, 1);
    chk("so_credit", credit, 25);
    step();
    chk("so_one_cycle", sold_out, 0);
    stock = 4'b1111;
    sel = 4'b1000; step(); sel = '0;
    chk("ic_no_req", disp_req, 0);
    chk("ic_credit", credit, 25);
    chk("ic_no_sold", sold_out, 0);
    chk("ic_busy", busy, 0);
    put_dime();
    chk("ic_still_credit", credit, 35);
    sel = 4'b0110; step(); sel = '0;
    chk("ms_ignored", disp_req, 0);

    // Timeout: 35c refunded as one quarter + two nickels
    sel = 4'b0100; step(); sel = '0;
    chk("to_req", disp_req, 1);
    chk("to_credit0", credit, 0);
    for (int i = 0; i < int'(DT) - 1; i++) step();
    chk("to_not_yet", fault, 0);
    chk("to_req_late", disp_req, 1);
    step();
    chk("to_fault", fault, 1);
    chk("to_req_drop", disp_req, 0);
    chk("to_refund", credit, 35);
    chk("to_busy", busy, 1);
    change_coin("to_q1", 1'b1, 10);
    chk("to_fault_pulse", fault, 0);
    change_coin("to_n1", 1'b0, 5);
    change_coin("to_n2", 1'b0, 0);
    chk("to_idle", busy, 0);

    // Cancel with 10c, and cancel in IDLE ignored
    put_dime();
    cancel = 1'b1; sel = 4'b0001; step(); cancel = 1'b0; sel = '0;
    chk("cn_busy", busy, 1);
    chk("cn_no_vend", disp_req, 0);
    change_coin("cn_n1", 1'b0, 5);
    change_coin("cn_n2", 1'b0, 0);
    chk("cn_idle", busy, 0);
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("cn_idle_ignored", busy, 0);

    // Reset held two cycles in the middle of a change payout
    put_dime();
    cancel = 1'b1; step(); cancel = 1'b0;
    step();
    chk("rs_pre_req", chg_req, 1);
    rst_n = 1'b0;
    step();
    chk("rs_req_drop", chg_req, 0);
    chk("rs_credit", credit, 0);
    chk("rs_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rs_after_req", chg_req, 0);
    chk("rs_after_credit", credit, 0);
    chk("rs_after_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
